cdc_rd_packer: RTL

//  Read-side consumer of the 2-entry toggle-pointer CDC FIFO, in the read clock domain.

---
 rtl/cdc_rd_packer.sv | 85 ++++++++
 1 files changed

// File: rtl/cdc_rd_packer.sv
// rtl/cdc_rd_packer.sv - packs RATIO FIFO beats into one wide word with flush-driven partial words
// Read-domain consumer of the toggle-pointer CDC FIFO; one-word output register on a valid/ready port.
module cdc_rd_packer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4,
  localparam int NW    = $clog2(RATIO + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_rrdy,
  output logic                      in_ren,
  input  logic [DWIDTH-1:0]         in_rdata,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DWIDTH*RATIO-1:0]   out_data,
  output logic [NW-1:0]             out_num
);

  localparam logic [NW-1:0] LAST = NW'(RATIO - 1);

  logic [NW-1:0]           cnt;
  logic [DWIDTH*RATIO-1:0] acc;
  logic [DWIDTH*RATIO-1:0] acc_next;
  logic                    flush_pend;
  logic                    slot_free;
  logic                    pop;
  logic                    word_done;
  logic                    flush_req;
  logic                    serve;

  assign slot_free = ~out_valid | out_ready;
  // The last lane may only be popped when the completed word has somewhere to go.
  assign in_ren    = ~rst & ((cnt < LAST) | slot_free);
  assign pop       = in_ren & in_rrdy;
  assign word_done = pop & (cnt == LAST);
  assign flush_req = flush_pend | flush;
  assign serve     = flush_req & slot_free & ((cnt != '0) | pop) & ~word_done;

  // Lanes above cnt are always zero, so this doubles as the outgoing word on complete or flush.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (pop && (cnt == NW'(i))) begin
        acc_next[i*DWIDTH +: DWIDTH] = in_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_num    <= '0;
    end else if (word_done) begin
      out_data   <= acc_next;
      out_num    <= NW'(RATIO);
      out_valid  <= 1'b1;
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else if (serve) begin
      out_data   <= acc_next;
      out_num    <= cnt + NW'(pop);
      out_valid  <= 1'b1;
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (pop) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A flush with nothing accumulated is dropped rather than producing an empty word.
      flush_pend <= flush_req & ((cnt != '0) | pop);
    end
  end

endmodule
